gp_lpddr5_cmd_scheduler: RTL
============================

GP_LPDDR5_CMD_SCHEDULER -- requirements
Module: gp_lpddr5_cmd_scheduler

Interface
REQ-001 SHALL have parameter T_RCD, default 4: minimum ck_t cycles from the ACT2 cycle to the CAS cycle.
REQ-002 SHALL have parameter T_RP, default 4: minimum cycles from PRE to the next ACT1 or REF.
REQ-003 SHALL have parameter T_REFI, default 64: refresh interval in cycles.
REQ-004 SHALL have parameter T_RFC, default 8: cycles after REF before any new command.
REQ-005 SHALL have port ck_t, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port ddr_reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port req_valid, input, 1 bit: a command request is present.
REQ-008 SHALL have port req_cmd, input, 2 bits: requested command; 0 = ACT, 1 = RD16, 2 = WR16, 3 = PRE.
REQ-009 SHALL have port req_ready, output, 1 bit: the request is accepted this cycle.
REQ-010 SHALL have port cs, output, 1 bit: chip select; high only in cycles that drive a command.
REQ-011 SHALL have port ca, output, 7 bits, indexed [0:6]: command/address bus.
REQ-012 SHALL have port row_open, output, 1 bit: the single modelled bank is active.
REQ-013 SHALL have port ref_busy, output, 1 bit: a refresh sequence is pending or in progress.
REQ-014 SHALL have port err, output, 1 bit: one-cycle pulse on an illegal request.

Function
REQ-015 SHALL drive these CA codes, each for one cycle with cs = 1:
- ACT1 = 1110000, ACT2 = 1100000
- CAS_WR = 0011100, CAS_RD = 0011010
- WR16 = 0110000, RD16 = 1000000
- PRE = 0001111, REF = 0001110
REQ-016 SHALL drive cs = 0 and ca = 0000000 in every cycle without a command.
REQ-017 SHALL implement states IDLE, ACT2, TRCD_WAIT, CAS, RDWR, TRP_WAIT, REF_PRE, REF_CMD, TRFC_WAIT.
REQ-018 SHALL assert req_ready only in IDLE, when ref_busy = 0 and the applicable timer has expired; a handshake is req_valid and req_ready in the same cycle.
REQ-019 ACT accepted with row_open = 0:
- ACT1 is driven the cycle after the handshake, ACT2 the following cycle.
- row_open = 1 from the ACT2 cycle onward.
REQ-020 RD16/WR16 accepted with row_open = 1:
- CAS_RD or CAS_WR is driven the cycle after the handshake, RD16 or WR16 the cycle after that.
- The CAS cycle is never earlier than T_RCD cycles after ACT2; TRCD_WAIT holds until then.
REQ-021 PRE accepted with row_open = 1:
- PRE is driven the cycle after the handshake.
- row_open = 0 from that cycle onward.
- The T_RP counter is loaded at the PRE cycle.
REQ-022 ACT with row_open = 1, RD16/WR16 with row_open = 0, and PRE with row_open = 0 SHALL be accepted, drive no CA command, and pulse err the cycle after the handshake.
REQ-023 SHALL load a refresh down-counter with T_REFI-1 at reset and after every REF, and decrement it each cycle.
REQ-024 SHALL set ref_busy when the counter reaches 0, and hold it through the end of TRFC_WAIT.
REQ-025 When ref_busy is set in IDLE:
- With row_open = 1: issue PRE (REF_PRE), wait T_RP, issue REF.
- With row_open = 0: issue REF after any outstanding T_RP has expired.
- After REF, wait T_RFC cycles, then return to IDLE.
REQ-026 Refresh SHALL win over a simultaneous req_valid; req_ready = 0 in that cycle.
REQ-027 A refresh falling due mid-sequence (ACT2, CAS, RDWR) SHALL wait until the sequence completes and IDLE is reached.
REQ-028 Timers SHALL saturate at 0, never wrap, and be sized ceil(log2(max parameter + 1)).

Reset
REQ-029 While ddr_reset = 1:
- state = IDLE; req_ready, cs, row_open, ref_busy and err = 0; ca = 0000000.
- All timers are cleared and the refresh counter is loaded with T_REFI-1.
REQ-030 Reset asserted mid-sequence SHALL abort immediately, with no partial command driven after the reset edge.

Verification
REQ-031 ACT at cycle 10 -> ACT1 at cycle 11, ACT2 at cycle 12, row_open = 1 from cycle 12.
REQ-032 RD16 requested at cycle 13 after ACT2 at cycle 12 -> CAS_RD no earlier than cycle 16, RD16 on the following cycle.
REQ-033 PRE at cycle 20, then ACT at cycle 21 -> req_ready = 0 until cycle 24, ACT1 no earlier than cycle 25.
REQ-034 Row open when the refresh counter expires -> PRE, then after T_RP cycles REF (0001110), ref_busy = 1 until T_RFC cycles after REF, and a concurrent req_valid is stalled.
REQ-035 RD16 with row_open = 0 -> err pulses for one cycle, cs stays 0.
REQ-036 ddr_reset asserted between ACT1 and ACT2 -> cs = 0 and row_open = 0 immediately, no ACT2 is driven.

Source files
------------

// File: rtl/gp_lpddr5_cmd_scheduler.sv
// gp_lpddr5_cmd_scheduler
// Single-bank LPDDR5 command scheduler. It accepts ACT / RD16 / WR16 / PRE
// requests one at a time. It expands ACT into the two-cycle ACT1/ACT2 pair
// and RD16/WR16 into CAS followed by the data command. It enforces tRCD,
// tRP and tRFC, and it inserts periodic refreshes. A refresh closes the open
// row first if needed.
//
// Ports
//   ck_t       : clock, all state updates on the rising edge
//   ddr_reset  : asynchronous active-high reset
//   req_valid  : a command request is present
//   req_cmd    : 0 = ACT, 1 = RD16, 2 = WR16, 3 = PRE
//   req_ready  : request accepted this cycle (handshake = req_valid & req_ready)
//   cs         : chip select, high only in cycles that carry a command
//   ca[0:6]    : command/address bus, all zero when idle
//   row_open   : the modelled bank is active
//   ref_busy   : a refresh is pending or in progress
//   err        : one-cycle pulse after an illegal request was accepted
//
// cs/ca are registered. The command decided in a given state appears on the
// bus in the following cycle. The ACT2 state is therefore the cycle in which
// ACT1 is on the bus, and it launches ACT2.
module gp_lpddr5_cmd_scheduler #(
  parameter int T_RCD  = 4,
  parameter int T_RP   = 4,
  parameter int T_REFI = 64,
  parameter int T_RFC  = 8
) (
  input  logic       ck_t,
  input  logic       ddr_reset,
  input  logic       req_valid,
  input  logic [1:0] req_cmd,
  output logic       req_ready,
  output logic       cs,
  output logic [0:6] ca,
  output logic       row_open,
  output logic       ref_busy,
  output logic       err
);

  localparam int MAX_A = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int MAX_B = (T_REFI > T_RFC) ? T_REFI : T_RFC;
  localparam int MAXP  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int TW    = $clog2(MAXP + 1);

  localparam logic [0:6] CA_NOP    = 7'b0000000;
  localparam logic [0:6] CA_ACT1   = 7'b1110000;
  localparam logic [0:6] CA_ACT2   = 7'b1100000;
  localparam logic [0:6] CA_CAS_WR = 7'b0011100;
  localparam logic [0:6] CA_CAS_RD = 7'b0011010;
  localparam logic [0:6] CA_WR16   = 7'b0110000;
  localparam logic [0:6] CA_RD16   = 7'b1000000;
  localparam logic [0:6] CA_PRE    = 7'b0001111;
  localparam logic [0:6] CA_REF    = 7'b0001110;

  localparam logic [1:0] CMD_ACT  = 2'd0;
  localparam logic [1:0] CMD_RD16 = 2'd1;
  localparam logic [1:0] CMD_WR16 = 2'd2;
  localparam logic [1:0] CMD_PRE  = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ACT2,
    S_TRCD_WAIT,
    S_CAS,
    S_RDWR,
    S_TRP_WAIT,
    S_REF_PRE,
    S_REF_CMD,
    S_TRFC_WAIT
  } state_t;

  state_t        state_reg, state_next;
  logic          cs_reg, cs_next;
  logic [0:6]    ca_reg, ca_next;
  logic          row_open_reg, row_open_next;
  logic          ref_busy_reg, ref_busy_next;
  logic          err_reg, err_next;
  logic          is_wr_reg, is_wr_next;
  logic [TW-1:0] trcd_reg, trcd_next;
  logic [TW-1:0] trp_reg, trp_next;
  logic [TW-1:0] trfc_reg, trfc_next;
  logic [TW-1:0] ref_cnt_reg, ref_cnt_next;
  logic          ref_busy_clr;
  logic          ready;

  // Ready is gated by reset as well, because the reset state (IDLE with
  // expired timers) would otherwise look ready.
  assign ready = !ddr_reset && (state_reg == S_IDLE) && !ref_busy_reg &&
                 (trp_reg == '0) && (trfc_reg == '0);

  always_ff @(posedge ck_t or posedge ddr_reset) begin
    if (ddr_reset) begin
      state_reg    <= S_IDLE;
      cs_reg       <= 1'b0;
      ca_reg       <= CA_NOP;
      row_open_reg <= 1'b0;
      ref_busy_reg <= 1'b0;
      err_reg      <= 1'b0;
      is_wr_reg    <= 1'b0;
      trcd_reg     <= '0;
      trp_reg      <= '0;
      trfc_reg     <= '0;
      ref_cnt_reg  <= TW'(T_REFI - 1);
    end else begin
      state_reg    <= state_next;
      cs_reg       <= cs_next;
      ca_reg       <= ca_next;
      row_open_reg <= row_open_next;
      ref_busy_reg <= ref_busy_next;
      err_reg      <= err_next;
      is_wr_reg    <= is_wr_next;
      trcd_reg     <= trcd_next;
      trp_reg      <= trp_next;
      trfc_reg     <= trfc_next;
      ref_cnt_reg  <= ref_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cs_next       = 1'b0;
    ca_next       = CA_NOP;
    row_open_next = row_open_reg;
    err_next      = 1'b0;
    is_wr_next    = is_wr_reg;
    ref_busy_clr  = 1'b0;
    // All timers count down and stick at zero unless reloaded below.
    trcd_next     = (trcd_reg != '0) ? trcd_reg - 1'b1 : '0;
    trp_next      = (trp_reg != '0) ? trp_reg - 1'b1 : '0;
    trfc_next     = (trfc_reg != '0) ? trfc_reg - 1'b1 : '0;
    ref_cnt_next  = (ref_cnt_reg != '0) ? ref_cnt_reg - 1'b1 : '0;

    case (state_reg)
      S_IDLE: begin
        if (ref_busy_reg) begin
          if (row_open_reg) begin
            cs_next       = 1'b1;
            ca_next       = CA_PRE;
            row_open_next = 1'b0;
            trp_next      = TW'(T_RP - 1);
            state_next    = S_REF_PRE;
          end else if (trp_reg == '0) begin
            cs_next      = 1'b1;
            ca_next      = CA_REF;
            ref_cnt_next = TW'(T_REFI - 1);
            trfc_next    = TW'(T_RFC - 1);
            state_next   = S_REF_CMD;
          end
        end else if (req_valid && ready) begin
          case (req_cmd)
            CMD_ACT: begin
              if (!row_open_reg) begin
                cs_next    = 1'b1;
                ca_next    = CA_ACT1;
                state_next = S_ACT2;
              end else begin
                err_next = 1'b1;
              end
            end
            CMD_RD16, CMD_WR16: begin
              if (row_open_reg) begin
                is_wr_next = (req_cmd == CMD_WR16);
                // CAS may go out next cycle only if tRCD is already satisfied.
                if (trcd_reg == '0) begin
                  cs_next    = 1'b1;
                  ca_next    = (req_cmd == CMD_WR16) ? CA_CAS_WR : CA_CAS_RD;
                  state_next = S_CAS;
                end else begin
                  state_next = S_TRCD_WAIT;
                end
              end else begin
                err_next = 1'b1;
              end
            end
            default: begin  // PRE
              if (row_open_reg) begin
                cs_next       = 1'b1;
                ca_next       = CA_PRE;
                row_open_next = 1'b0;
                trp_next      = TW'(T_RP - 1);
                state_next    = S_TRP_WAIT;
              end else begin
                err_next = 1'b1;
              end
            end
          endcase
        end
      end

      S_ACT2: begin
        cs_next       = 1'b1;
        ca_next       = CA_ACT2;
        row_open_next = 1'b1;
        trcd_next     = TW'(T_RCD - 1);
        state_next    = S_IDLE;
      end

      S_TRCD_WAIT: begin
        if (trcd_reg == '0) begin
          cs_next    = 1'b1;
          ca_next    = is_wr_reg ? CA_CAS_WR : CA_CAS_RD;
          state_next = S_CAS;
        end
      end

      S_CAS: begin
        cs_next    = 1'b1;
        ca_next    = is_wr_reg ? CA_WR16 : CA_RD16;
        state_next = S_RDWR;
      end

      S_RDWR: state_next = S_IDLE;

      // Leave one cycle early so IDLE coincides with the timer reaching zero
      // and the next command can be launched exactly tRP after PRE.
      S_TRP_WAIT: begin
        if (trp_reg <= TW'(1)) state_next = S_IDLE;
      end

      S_REF_PRE: begin
        if (trp_reg == '0) begin
          cs_next      = 1'b1;
          ca_next      = CA_REF;
          ref_cnt_next = TW'(T_REFI - 1);
          trfc_next    = TW'(T_RFC - 1);
          state_next   = S_REF_CMD;
        end
      end

      S_REF_CMD: state_next = S_TRFC_WAIT;

      S_TRFC_WAIT: begin
        if (trfc_reg <= TW'(1)) begin
          state_next   = S_IDLE;
          ref_busy_clr = 1'b1;
        end
      end

      default: state_next = S_IDLE;
    endcase

    // ref_busy rises in the cycle the refresh counter reads zero. The counter
    // stays at zero while a refresh is deferred, so ref_busy stays high until
    // the tRFC wait completes.
    ref_busy_next = ref_busy_clr ? 1'b0 : (ref_busy_reg || (ref_cnt_next == '0));
  end

  assign req_ready = ready;
  assign cs        = cs_reg;
  assign ca        = ca_reg;
  assign row_open  = row_open_reg;
  assign ref_busy  = ref_busy_reg;
  assign err       = err_reg;

endmodule
